// File: rtl/crop_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crop_capture_ctrl
// Purpose  : One-shot capture sequencer for the 28x28 crop/downsample path.
//            Optional timeout guard: define CROP_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module crop_capture_ctrl #(
    parameter int N_SAMPLES   = 784,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TMO_W       = 21
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iFrameStart,
    input  logic             iDVAL,
    input  logic             iSampleStrobe,
    input  logic             iAck,
    output logic             oCapDVAL,
    output logic             oBufRst,
    output logic             oImgValid,
    output logic             oBusy,
    output logic [CNT_W-1:0] oSampleCnt,
    output logic [7:0]       oFrameCnt,
    output logic             oErr
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HANDOFF = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N_SAMPLES - 1);

    generate
        if (CNT_W < $clog2(N_SAMPLES + 1) || TMO_W < $clog2(TIMEOUT_CYC)) begin : g_param_check
            $error("crop_capture_ctrl: counter width too small for its limit");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             buf_rst_q, buf_rst_d;
    logic             img_valid_q, img_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             timeout_hit;

`ifdef CROP_TIMEOUT_EN
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_active;

    assign tmo_active  = (state_q == ST_ARM) || (state_q == ST_CLEAR) || (state_q == ST_CAPTURE);
    assign timeout_hit = tmo_active && (tmo_cnt_q == C_TMO_LAST);

    // Held at zero while idle so every ARM entry starts from a clean count.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (tmo_active) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        buf_rst_d    = 1'b0;
        img_valid_d  = img_valid_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d     = ST_ARM;
                    err_d       = 1'b0;
                    frame_cnt_d = '0;
                end
            end
            ST_ARM: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (iFrameStart) begin
                    state_d      = ST_CLEAR;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    buf_rst_d    = 1'b1;
                    sample_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A completing strobe beats the timeout; a frame start beats the strobe.
                if (iSampleStrobe && !iFrameStart && (sample_cnt_q == C_CNT_LAST)) begin
                    state_d      = ST_HANDOFF;
                    sample_cnt_d = C_CNT_MAX;
                    img_valid_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (iFrameStart) begin
                    state_d      = ST_CLEAR;
                    err_d        = 1'b1;
                    buf_rst_d    = 1'b1;
                    sample_cnt_d = '0;
                end else if (iSampleStrobe && (sample_cnt_q != C_CNT_MAX)) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            ST_HANDOFF: begin
                if (iAck) begin
                    state_d     = ST_IDLE;
                    img_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                img_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            buf_rst_q    <= 1'b0;
            img_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            buf_rst_q    <= buf_rst_d;
            img_valid_q  <= img_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign oCapDVAL   = iDVAL && (state_q == ST_CAPTURE);
    assign oBufRst    = buf_rst_q;
    assign oImgValid  = img_valid_q;
    assign oBusy      = busy_q;
    assign oSampleCnt = sample_cnt_q;
    assign oFrameCnt  = frame_cnt_q;
    assign oErr       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_crop_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_crop_capture_ctrl
// Purpose  : Directed self-checking bench for crop_capture_ctrl.
// Revision : 1.0
// ============================================================================
module tb_crop_capture_ctrl;

`ifdef CROP_TIMEOUT_EN
    localparam int C_TMO = 100;
`else
    localparam int C_TMO = 2000000;
`endif
    localparam int C_N     = 784;
    localparam int C_CNT_W = 10;

    logic               iCLK = 1'b0;
    logic               iRST = 1'b1;
    logic               iStart = 1'b0;
    logic               iFrameStart = 1'b0;
    logic               iDVAL = 1'b0;
    logic               iSampleStrobe = 1'b0;
    logic               iAck = 1'b0;
    logic               oCapDVAL;
    logic               oBufRst;
    logic               oImgValid;
    logic               oBusy;
    logic [C_CNT_W-1:0] oSampleCnt;
    logic [7:0]         oFrameCnt;
    logic               oErr;

    int n_tests = 0;
    int n_fail  = 0;

    crop_capture_ctrl #(
        .N_SAMPLES   (C_N),
        .CNT_W       (C_CNT_W),
        .TIMEOUT_CYC (C_TMO),
        .TMO_W       (21)
    ) u_dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iStart        (iStart),
        .iFrameStart   (iFrameStart),
        .iDVAL         (iDVAL),
        .iSampleStrobe (iSampleStrobe),
        .iAck          (iAck),
        .oCapDVAL      (oCapDVAL),
        .oBufRst       (oBufRst),
        .oImgValid     (oImgValid),
        .oBusy         (oBusy),
        .oSampleCnt    (oSampleCnt),
        .oFrameCnt     (oFrameCnt),
        .oErr          (oErr)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic strobes(input int n);
        iSampleStrobe = 1'b1;
        step(n);
        iSampleStrobe = 1'b0;
    endtask

    // IDLE -> ARM -> CLEAR -> CAPTURE
    task automatic arm_and_start();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        iFrameStart = 1'b1;
        step();
        iFrameStart = 1'b0;
        step();
    endtask

    initial begin
        iDVAL = 1'b1;
        step(3);
        check("rst_busy", oBusy, 0);
        check("rst_img", oImgValid, 0);
        check("rst_bufrst", oBufRst, 0);
        check("rst_cnt", oSampleCnt, 0);
        check("rst_frame", oFrameCnt, 0);
        check("rst_err", oErr, 0);
        check("rst_capdval", oCapDVAL, 0);
        iRST = 1'b0;
        iDVAL = 1'b0;
        step();

`ifdef CROP_TIMEOUT_EN
        // T6: no frame pulse, timeout returns to IDLE with error
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        step(C_TMO - 1);
        check("t6_busy_before", oBusy, 1);
        check("t6_err_before", oErr, 0);
        step();
        check("t6_busy_after", oBusy, 0);
        check("t6_err_after", oErr, 1);
        step(3);
        check("t6_err_sticky", oErr, 1);
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        check("t6_err_cleared", oErr, 0);
        check("t6_rearmed", oBusy, 1);
`else
        // T2: normal capture with ignores (T5) mixed in
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        check("t2_busy_arm", oBusy, 1);
        check("t2_frame0", oFrameCnt, 0);
        iAck = 1'b1;
        iDVAL = 1'b1;
        iSampleStrobe = 1'b1;
        step(3);
        iAck = 1'b0;
        iSampleStrobe = 1'b0;
        check("t5_ack_in_arm_busy", oBusy, 1);
        check("t5_arm_capdval", oCapDVAL, 0);
        check("t5_arm_cnt", oSampleCnt, 0);
        check("t2_arm_bufrst", oBufRst, 0);
        iFrameStart = 1'b1;
        step();
        iFrameStart = 1'b0;
        check("t2_clear_bufrst", oBufRst, 1);
        check("t2_frame1", oFrameCnt, 1);
        step();
        check("t2_capture_bufrst", oBufRst, 0);
        check("t2_capdval_hi", oCapDVAL, 1);
        iDVAL = 1'b0;
        #1;
        check("t2_capdval_lo", oCapDVAL, 0);
        strobes(C_N - 1);
        check("t2_cnt_783", oSampleCnt, C_N - 1);
        check("t2_img_early", oImgValid, 0);
        strobes(1);
        iDVAL = 1'b1;
        #1;
        check("t2_img", oImgValid, 1);
        check("t2_cnt_784", oSampleCnt, C_N);
        check("t2_handoff_capdval", oCapDVAL, 0);
        iStart = 1'b1;
        iSampleStrobe = 1'b1;
        step(3);
        iStart = 1'b0;
        iSampleStrobe = 1'b0;
        check("t5_handoff_cnt", oSampleCnt, C_N);
        check("t5_handoff_img", oImgValid, 1);
        check("t5_handoff_busy", oBusy, 1);
        iAck = 1'b1;
        step();
        iAck = 1'b0;
        check("t2_ack_img", oImgValid, 0);
        check("t2_ack_busy", oBusy, 0);
        check("t2_err", oErr, 0);
        iDVAL = 1'b0;

        // T3: short frame restarts capture
        arm_and_start();
        strobes(500);
        check("t3_cnt_500", oSampleCnt, 500);
        iFrameStart = 1'b1;
        step();
        iFrameStart = 1'b0;
        check("t3_err", oErr, 1);
        check("t3_bufrst", oBufRst, 1);
        check("t3_cnt_zero", oSampleCnt, 0);
        check("t3_busy", oBusy, 1);
        step();
        check("t3_bufrst_drop", oBufRst, 0);
        strobes(C_N);
        check("t3_img", oImgValid, 1);
        check("t3_cnt", oSampleCnt, C_N);
        check("t3_err_sticky", oErr, 1);
        iAck = 1'b1;
        step();
        iAck = 1'b0;

        // T4: frame start collides with the completing strobe
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        check("t4_err_cleared", oErr, 0);
        iFrameStart = 1'b1;
        step();
        iFrameStart = 1'b0;
        step();
        strobes(C_N - 1);
        check("t4_cnt_783", oSampleCnt, C_N - 1);
        iFrameStart = 1'b1;
        iSampleStrobe = 1'b1;
        step();
        iFrameStart = 1'b0;
        iSampleStrobe = 1'b0;
        check("t4_img", oImgValid, 0);
        check("t4_err", oErr, 1);
        check("t4_bufrst", oBufRst, 1);
        check("t4_cnt", oSampleCnt, 0);
        step();
        check("t4_no_handoff", oImgValid, 0);

        // T1: asynchronous reset in the middle of a capture
        strobes(10);
        check("t1_cnt_10", oSampleCnt, 10);
        iDVAL = 1'b1;
        #2;
        check("t1_capdval_pre", oCapDVAL, 1);
        iRST = 1'b1;
        #1;
        check("t1_capdval", oCapDVAL, 0);
        check("t1_busy", oBusy, 0);
        check("t1_img", oImgValid, 0);
        check("t1_bufrst", oBufRst, 0);
        check("t1_cnt", oSampleCnt, 0);
        check("t1_err", oErr, 0);
        step();
        iRST = 1'b0;
        iDVAL = 1'b0;
        step(2);
        check("t1_idle_after", oBusy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
